// File: rtl/gps_receiver.sv
// rtl/gps_receiver.sv - NMEA $GPZDA sentence parser producing binary UTC time and date
// Optional build macro GPS_RECEIVER_CHECKSUM_EN: compare the transmitted *CC against the XOR of the sentence body.
module gps_receiver #(
    parameter int B = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [B-1:0] data,
    output logic [4:0]   hour,
    output logic [5:0]   minute,
    output logic [5:0]   second,
    output logic [6:0]   centisec,
    output logic [4:0]   day,
    output logic [3:0]   month,
    output logic [11:0]  year,
    output logic         valid,
    output logic         error
);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_DASH   = 8'h2D;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE, ST_HEADER, ST_TIME, ST_DAY, ST_MONTH, ST_YEAR,
        ST_ZONE_H, ST_ZONE_M, ST_CSUM, ST_CR, ST_LF
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [4:0]  hour_s_q;
    logic [5:0]  min_s_q;
    logic [5:0]  sec_s_q;
    logic [6:0]  cs_s_q;
    logic [4:0]  day_s_q;
    logic [3:0]  mon_s_q;
    logic [11:0] year_s_q;
    logic [4:0]  hour_q;
    logic [5:0]  min_q;
    logic [5:0]  sec_q;
    logic [6:0]  cs_q;
    logic [4:0]  day_q;
    logic [3:0]  mon_q;
    logic [11:0] year_q;
    logic        valid_q;
    logic        error_q;
`ifdef GPS_RECEIVER_CHECKSUM_EN
    logic [7:0]  csum_q;
    logic [7:0]  rx_csum_q;
    logic [3:0]  hex_val;
`endif

    logic [7:0] c;
    logic       is_dig;
    logic [3:0] dig;
    logic       is_hex;
    logic [7:0] hdr_c;

    assign c = data[7:0];

    // Character classification and the expected header character for the current position
    always_comb begin
        is_dig = (c >= 8'h30) && (c <= 8'h39);
        dig    = c[3:0];
        is_hex = is_dig || ((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66));
`ifdef GPS_RECEIVER_CHECKSUM_EN
        hex_val = is_dig ? c[3:0] : 4'(c[3:0] + 4'd9);
`endif
        case (cnt_q)
            4'd0:    hdr_c = 8'h47;
            4'd1:    hdr_c = 8'h50;
            4'd2:    hdr_c = 8'h5A;
            4'd3:    hdr_c = 8'h44;
            4'd4:    hdr_c = 8'h41;
            default: hdr_c = CH_COMMA;
        endcase
    end

    // Sentence FSM: field accumulation, checksum, abort handling and registered result pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hour_s_q <= '0; min_s_q <= '0; sec_s_q  <= '0; cs_s_q <= '0;
            day_s_q  <= '0; mon_s_q <= '0; year_s_q <= '0;
            hour_q   <= '0; min_q   <= '0; sec_q    <= '0; cs_q   <= '0;
            day_q    <= '0; mon_q   <= '0; year_q   <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
`ifdef GPS_RECEIVER_CHECKSUM_EN
            csum_q    <= '0;
            rx_csum_q <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            if (load) begin
                if (c == CH_DOLLAR) begin
                    // A new '$' always restarts cleanly, whatever was in flight
                    state_q  <= ST_HEADER;
                    cnt_q    <= '0;
                    hour_s_q <= '0; min_s_q <= '0; sec_s_q  <= '0; cs_s_q <= '0;
                    day_s_q  <= '0; mon_s_q <= '0; year_s_q <= '0;
`ifdef GPS_RECEIVER_CHECKSUM_EN
                    csum_q   <= '0;
`endif
                end else begin
`ifdef GPS_RECEIVER_CHECKSUM_EN
                    // Body bytes between '$' and '*' feed the running XOR
                    if (state_q inside {ST_HEADER, ST_TIME, ST_DAY, ST_MONTH, ST_YEAR,
                                        ST_ZONE_H, ST_ZONE_M} && c != CH_STAR)
                        csum_q <= csum_q ^ c;
`endif
                    case (state_q)
                        ST_IDLE: ;
                        ST_HEADER:
                            if (c != hdr_c) begin state_q <= ST_IDLE; error_q <= 1'b1; end
                            else if (cnt_q == 4'd5) begin state_q <= ST_TIME; cnt_q <= '0; end
                            else cnt_q <= cnt_q + 4'd1;
                        ST_TIME:
                            if (cnt_q == 4'd9) begin
                                if (c == CH_COMMA) begin state_q <= ST_DAY; cnt_q <= '0; end
                                else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                            end else if (cnt_q == 4'd6) begin
                                if (c == CH_DOT) cnt_q <= cnt_q + 4'd1;
                                else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                            end else if (is_dig) begin
                                case (cnt_q)
                                    4'd0, 4'd1: hour_s_q <= 5'(32'(hour_s_q) * 32'd10 + 32'(dig));
                                    4'd2, 4'd3: min_s_q  <= 6'(32'(min_s_q) * 32'd10 + 32'(dig));
                                    4'd4, 4'd5: sec_s_q  <= 6'(32'(sec_s_q) * 32'd10 + 32'(dig));
                                    default:    cs_s_q   <= 7'(32'(cs_s_q) * 32'd10 + 32'(dig));
                                endcase
                                cnt_q <= cnt_q + 4'd1;
                            end else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                        ST_DAY, ST_MONTH:
                            if (cnt_q == 4'd2) begin
                                if (c == CH_COMMA) begin
                                    state_q <= (state_q == ST_DAY) ? ST_MONTH : ST_YEAR;
                                    cnt_q   <= '0;
                                end else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                            end else if (is_dig) begin
                                if (state_q == ST_DAY) day_s_q <= 5'(32'(day_s_q) * 32'd10 + 32'(dig));
                                else                   mon_s_q <= 4'(32'(mon_s_q) * 32'd10 + 32'(dig));
                                cnt_q <= cnt_q + 4'd1;
                            end else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                        ST_YEAR:
                            if (cnt_q == 4'd4) begin
                                if (c == CH_COMMA) begin state_q <= ST_ZONE_H; cnt_q <= '0; end
                                else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                            end else if (is_dig) begin
                                year_s_q <= 12'(32'(year_s_q) * 32'd10 + 32'(dig));
                                cnt_q    <= cnt_q + 4'd1;
                            end else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                        ST_ZONE_H, ST_ZONE_M:
                            if ((state_q == ST_ZONE_H && c == CH_COMMA) ||
                                (state_q == ST_ZONE_M && c == CH_STAR)) begin
                                state_q <= (state_q == ST_ZONE_H) ? ST_ZONE_M : ST_CSUM;
                                cnt_q   <= '0;
                            end else if (cnt_q < 4'd2 && (is_dig || c == CH_DASH)) begin
                                cnt_q <= cnt_q + 4'd1;
                            end else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                        ST_CSUM:
                            if (is_hex) begin
`ifdef GPS_RECEIVER_CHECKSUM_EN
                                rx_csum_q <= {rx_csum_q[3:0], hex_val};
`endif
                                if (cnt_q == 4'd1) state_q <= ST_CR;
                                else cnt_q <= cnt_q + 4'd1;
                            end else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                        ST_CR:
                            if (c == CH_CR) state_q <= ST_LF;
                            else begin state_q <= ST_IDLE; error_q <= 1'b1; end
                        ST_LF: begin
                            state_q <= ST_IDLE;
`ifdef GPS_RECEIVER_CHECKSUM_EN
                            if (c == CH_LF && rx_csum_q == csum_q) begin
`else
                            if (c == CH_LF) begin
`endif
                                hour_q <= hour_s_q; min_q <= min_s_q; sec_q  <= sec_s_q;
                                cs_q   <= cs_s_q;   day_q <= day_s_q; mon_q  <= mon_s_q;
                                year_q <= year_s_q;
                                valid_q <= 1'b1;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign hour     = hour_q;
    assign minute   = min_q;
    assign second   = sec_q;
    assign centisec = cs_q;
    assign day      = day_q;
    assign month    = mon_q;
    assign year     = year_q;
    assign valid    = valid_q;
    assign error    = error_q;

endmodule

// File: tb/tb_gps_receiver.sv
// tb/tb_gps_receiver.sv - self-checking bench for gps_receiver: vector table, corner sequences, random sentences vs model
module tb_gps_receiver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load  = 1'b0;
    logic [7:0]  data  = 8'h00;
    logic [4:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic [6:0]  centisec;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic        valid;
    logic        error;

    gps_receiver #(.B(8)) dut (
        .clock(clock), .reset(reset), .load(load), .data(data),
        .hour(hour), .minute(minute), .second(second), .centisec(centisec),
        .day(day), .month(month), .year(year), .valid(valid), .error(error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_error  = 0;
    int n_both   = 0;
    int eh, em, es, ec, ed, emo, ey;
    int mh, mm, ms, mc, md, mmo, my;

    always @(negedge clock) begin
        if (valid) n_valid++;
        if (error) n_error++;
        if (valid && error) n_both++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time (got timeout, required finish)");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", nm, act, exp);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_hour"},     int'(hour),     eh);
        chk({tag, "_minute"},   int'(minute),   em);
        chk({tag, "_second"},   int'(second),   es);
        chk({tag, "_centisec"}, int'(centisec), ec);
        chk({tag, "_day"},      int'(day),      ed);
        chk({tag, "_month"},    int'(month),    emo);
        chk({tag, "_year"},     int'(year),     ey);
    endtask

    function automatic bit isdig(byte c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic int hexval(byte c);
        if (isdig(c)) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic int num(string s, int st, int n);
        int r = 0;
        for (int i = 0; i < n; i++) begin
            if (!isdig(s[st + i])) return -1;
            r = r * 10 + (int'(s[st + i]) - 48);
        end
        return r;
    endfunction

    function automatic int body_xor(string s, int stop);
        int x = 0;
        for (int i = 1; i < stop; i++) x = x ^ int'(s[i]);
        return x;
    endfunction

    // Appends *CC CR LF to a "$..." body, CC being the XOR of everything after '$'
    function automatic string mk(string body, bit lower);
        int x = body_xor(body, body.len());
        return {body, "*", $sformatf(lower ? "%02x" : "%02X", x), "\r\n"};
    endfunction

    // Reference: decides acceptance of a whole sentence from the textual grammar; fills m* on success
    function automatic bit model(string s);
        int p, k, star, h1, h2;
        int f[7];
        if (s.len() < 34) return 0;
        if (s.substr(0, 6) != "$GPZDA,") return 0;
        f[0] = num(s, 7, 2);  f[1] = num(s, 9, 2);  f[2] = num(s, 11, 2);
        f[3] = num(s, 14, 2); f[4] = num(s, 17, 2); f[5] = num(s, 20, 2);
        f[6] = num(s, 23, 4);
        for (int i = 0; i < 7; i++) if (f[i] < 0) return 0;
        if (s[13] != ".") return 0;
        if (s[16] != "," || s[19] != "," || s[22] != "," || s[27] != ",") return 0;
        p = 28; k = 0;
        while (p < s.len() && (isdig(s[p]) || s[p] == "-")) begin p++; k++; end
        if (k > 2 || p >= s.len() || s[p] != ",") return 0;
        p++; k = 0;
        while (p < s.len() && (isdig(s[p]) || s[p] == "-")) begin p++; k++; end
        if (k > 2 || p >= s.len() || s[p] != "*") return 0;
        star = p;
        if (s.len() != star + 5) return 0;
        h1 = hexval(s[star + 1]); h2 = hexval(s[star + 2]);
        if (h1 < 0 || h2 < 0) return 0;
        if (s[star + 3] != 8'h0D || s[star + 4] != 8'h0A) return 0;
`ifdef GPS_RECEIVER_CHECKSUM_EN
        if (body_xor(s, star) != h1 * 16 + h2) return 0;
`endif
        mh = f[0] % 32; mm = f[1] % 64; ms = f[2] % 64; mc = f[3] % 128;
        md = f[4] % 32; mmo = f[5] % 16; my = f[6] % 4096;
        return 1;
    endfunction

    task automatic send(string s, bit every);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clock); load = 1'b1; data = s[i];
            if (!every) begin @(negedge clock); load = 1'b0; data = 8'($urandom); end
        end
        @(negedge clock); load = 1'b0;
        repeat (4) @(negedge clock);
        #2;
    endtask

    typedef struct {
        string s;
        bit    every;
        int    nv, ne;
        int    h, m, sec, cs, d, mo, y;
    } vec_t;

    vec_t  tbl[5];
    string zone_chars = "0123456789-";
    string bad_chars  = "0123456789-,.*XaFGZ";

    initial begin
        int    nv0, ne0;
        string s, zh, zm;
        bit    ok;

        tbl[0] = '{"$GPZDB,143042.00,25,08,2005,,*6E\r\n", 1'b0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{"$GPZDA,143042.00,25,08,2005,,*6E\r\n", 1'b0, 1, 0, 14, 30, 42, 0, 25, 8, 2005};
`ifdef GPS_RECEIVER_CHECKSUM_EN
        tbl[2] = '{"$GPZDA,143042.00,25,08,2005,,*6F\r\n", 1'b0, 0, 1, 14, 30, 42, 0, 25, 8, 2005};
`else
        tbl[2] = '{"$GPZDA,143042.00,25,08,2005,,*6F\r\n", 1'b0, 1, 0, 14, 30, 42, 0, 25, 8, 2005};
`endif
        tbl[3] = '{{"$GPZDA,1430", mk("$GPZDA,235959.99,31,12,1999,-5,30", 1'b1)},
                   1'b0, 1, 0, 23, 59, 59, 99, 31, 12, 1999};
        tbl[4] = '{"$GPZDA,143042.00,25,08,2005,,*6E\r\n", 1'b1, 1, 0, 14, 30, 42, 0, 25, 8, 2005};

        // reset state
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        eh = 0; em = 0; es = 0; ec = 0; ed = 0; emo = 0; ey = 0;
        chk_outputs("reset");
        chk("reset_valid", int'(valid), 0);
        chk("reset_error", int'(error), 0);
        @(negedge clock); reset = 1'b0;

        // vector table
        for (int i = 0; i < 5; i++) begin
            nv0 = n_valid; ne0 = n_error;
            send(tbl[i].s, tbl[i].every);
            eh = tbl[i].h; em = tbl[i].m; es = tbl[i].sec; ec = tbl[i].cs;
            ed = tbl[i].d; emo = tbl[i].mo; ey = tbl[i].y;
            chk($sformatf("tbl%0d_valid_pulses", i), n_valid - nv0, tbl[i].nv);
            chk($sformatf("tbl%0d_error_pulses", i), n_error - ne0, tbl[i].ne);
            chk_outputs($sformatf("tbl%0d", i));
        end

        // valid latency and width with back-to-back loads
        s = mk("$GPZDA,000000.01,01,01,0001,12,-3", 1'b0);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clock); load = 1'b1; data = s[i];
        end
        @(negedge clock); load = 1'b0; #1;
        chk("lat_valid_after_lf", int'(valid), 1);
        eh = 0; em = 0; es = 0; ec = 1; ed = 1; emo = 1; ey = 1;
        chk_outputs("lat");
        @(negedge clock); #1;
        chk("lat_valid_one_cycle", int'(valid), 0);

        // error latency at the bad header character
        s = "$GPZDB";
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clock); load = 1'b1; data = s[i];
        end
        @(negedge clock); load = 1'b0; #1;
        chk("err_pulse_after_b", int'(error), 1);
        @(negedge clock); #1;
        chk("err_one_cycle", int'(error), 0);
        chk_outputs("err_hold");

        // reset in the middle of a sentence
        ne0 = n_error; nv0 = n_valid;
        send("$GPZDA,143042.00,25", 1'b0);
        @(negedge clock); reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        eh = 0; em = 0; es = 0; ec = 0; ed = 0; emo = 0; ey = 0;
        chk_outputs("midrst");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("midrst_no_error", n_error - ne0, 0);
        chk_outputs("midrst_after");
        send("$GPZDA,143042.00,25,08,2005,,*6E\r\n", 1'b0);
        eh = 14; em = 30; es = 42; ec = 0; ed = 25; emo = 8; ey = 2005;
        chk("midrst_valid_pulses", n_valid - nv0, 1);
        chk_outputs("midrst_full");

        // randomized sentences, some corrupted in one byte
        for (int it = 0; it < 80; it++) begin
            zh = ""; zm = "";
            for (int k = $urandom_range(0, 2); k > 0; k--)
                zh = {zh, zone_chars.substr($urandom_range(0, 10), $urandom_range(0, 10))};
            zh = zh.substr(0, (zh.len() > 2 ? 2 : zh.len()) - 1);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                int j = $urandom_range(0, 10);
                zm = {zm, zone_chars.substr(j, j)};
            end
            s = mk($sformatf("$GPZDA,%02d%02d%02d.%02d,%02d,%02d,%04d,%s,%s",
                     $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
                     $urandom_range(0, 99), $urandom_range(1, 31), $urandom_range(1, 12),
                     $urandom_range(0, 4095), zh, zm), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                int pos = $urandom_range(1, s.len() - 1);
                s.putc(pos, bad_chars[$urandom_range(0, bad_chars.len() - 1)]);
            end
            ok = model(s);
            nv0 = n_valid; ne0 = n_error;
            send(s, 1'($urandom_range(0, 1)));
            if (ok) begin eh = mh; em = mm; es = ms; ec = mc; ed = md; emo = mmo; ey = my; end
            chk($sformatf("rnd%0d_valid_pulses", it), n_valid - nv0, ok ? 1 : 0);
            chk($sformatf("rnd%0d_error_pulses", it), n_error - ne0, ok ? 0 : 1);
            chk_outputs($sformatf("rnd%0d", it));
        end

        chk("valid_error_never_together", n_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gps_receiver.md
GPS_RECEIVER -- requirements
Module: gps_receiver

Interface
REQ-001 Parameter: B, default 8, byte width of data input; only B=8 is supported.
REQ-002 Port: clock  input  1  sole clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: load  input  1  data byte valid this cycle; may be high on consecutive cycles or on alternate cycles.
REQ-005 Port: data  input  B  ASCII byte of the NMEA stream, sampled only when load=1.
REQ-006 Port: hour  output  5  UTC hour, binary 0-23.
REQ-007 Port: minute  output  6  UTC minute, binary 0-59.
REQ-008 Port: second  output  6  UTC second, binary 0-59.
REQ-009 Port: centisec  output  7  hundredths of a second, binary 0-99.
REQ-010 Port: day  output  5  day of month, binary.
REQ-011 Port: month  output  4  month, binary.
REQ-012 Port: year  output  12  year, binary 0-4095.
REQ-013 Port: valid  output  1  one-cycle pulse when a complete sentence is accepted.
REQ-014 Port: error  output  1  one-cycle pulse when a sentence is aborted.

Function
REQ-015 Accepted format: "$GPZDA,hhmmss.ss,dd,mm,yyyy,<zh>,<zm>*CC" followed by CR LF; <zh> and <zm> are optional and their contents are discarded.
REQ-016 FSM states: IDLE, HEADER, TIME, DAY, MONTH, YEAR, ZONE_H, ZONE_M, CSUM, CR, LF.
- IDLE waits for '$'.
- HEADER matches "GPZDA,".
- Each field state advances on ','.
- ZONE_M advances to CSUM on '*'.
- CSUM takes two hex digits, then expects CR, then LF.
REQ-017 The FSM advances only on cycles with load=1; cycles with load=0 change no state.
REQ-018 TIME field: exactly 6 digits, '.', then 2 digits; decimal digits accumulate into binary hour, minute, second and centisec shadow registers.
REQ-019 DAY and MONTH fields take exactly 2 digits; YEAR takes exactly 4 digits, converted via acc*10+digit.
REQ-020 Zone fields accept 0-2 characters from digits and '-'; those characters are ignored.
REQ-021 A '$' received in any state restarts the parse at HEADER and clears the shadow registers and the running checksum; error is not pulsed.
REQ-022 Any other unexpected byte (wrong header character, non-digit in a numeric field, wrong digit count, bad hex) pulses error and returns the FSM to IDLE.
REQ-023 On the cycle after the load cycle carrying LF in state LF, the shadow registers are copied to the outputs and valid=1 for exactly one cycle.
REQ-024 Outputs hold their last accepted values until the next accepted sentence; aborted sentences never alter them.
REQ-025 valid and error are never high in the same cycle.

Reset
REQ-026 While reset=1:
- FSM goes to IDLE.
- All shadow registers and the checksum clear.
- hour, minute, second, centisec, day, month, year, valid and error are 0.
REQ-027 Reset takes priority over load; a sentence in progress when reset asserts is discarded without an error pulse.

Configuration
REQ-028 Macro GPS_RECEIVER_CHECKSUM_EN defined: the checksum is the XOR of all bytes strictly between '$' and '*'; CC (hex, upper or lower case) must equal it, otherwise error pulses at LF and valid does not.
REQ-029 Macro GPS_RECEIVER_CHECKSUM_EN undefined: CC must be two hex characters but its value is ignored.

Verification
REQ-030 Reset for 2 cycles, then "$GPZDA,143042.00,25,08,2005,,*6E\r\n" (34 bytes, load on alternate cycles) -> one valid pulse after LF; hour=14, minute=30, second=42, centisec=0, day=25, month=8, year=2005.
REQ-031 Same sentence with CC changed to "6F" -> with macro defined: error pulse, outputs unchanged; with macro undefined: valid pulse.
REQ-032 Sentence containing "$GPZDB," -> error pulse at 'B', no valid pulse, outputs stay 0.
REQ-033 "$GPZDA,1430" followed by a full valid sentence -> no error pulse; valid pulse carries the second sentence's values.
REQ-034 Reset asserted mid-sentence, then a full sentence -> only the full sentence produces valid; all outputs are 0 before it.
REQ-035 Same sentence as REQ-030 with load high every cycle -> identical outputs; valid pulse one cycle after LF.
